// File: rtl/fv_pkg.sv
// rtl/fv_pkg.sv - shared constants and record layout for the fv flag reader blocks (FV_TIMESTAMP_EN)
package fv_pkg;
    localparam int FLAG_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int TS_W       = 8;
    localparam int DROP_W     = 4;
    localparam logic [DROP_W-1:0] DROP_SAT = '1;

`ifdef FV_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    typedef struct packed {
        logic [FLAG_W_DEF-1:0] flags;
        logic [TS_W-1:0]       ts;
    } fv_rec_t;
`else
    localparam bit TS_EN = 1'b0;
    typedef struct packed {
        logic [FLAG_W_DEF-1:0] flags;
    } fv_rec_t;
`endif

    function automatic int rec_w(input int flag_w);
        return flag_w + (TS_EN ? TS_W : 0);
    endfunction
endpackage

// File: rtl/fv_flag_reader_if.sv
// rtl/fv_flag_reader_if.sv - record stream between flag reader and consumer (REC_TS only with FV_TIMESTAMP_EN)
interface fv_flag_reader_if
    import fv_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF
);
    logic              REC_VALID;
    logic              REC_READY;
    logic [FLAG_W-1:0] REC_FLAGS;
`ifdef FV_TIMESTAMP_EN
    logic [TS_W-1:0]   REC_TS;

    modport master (input REC_READY, output REC_VALID, REC_FLAGS, REC_TS);
    modport slave  (output REC_READY, input REC_VALID, REC_FLAGS, REC_TS);
`else
    modport master (input REC_READY, output REC_VALID, REC_FLAGS);
    modport slave  (output REC_READY, input REC_VALID, REC_FLAGS);
`endif
endinterface

// File: rtl/fv_sync_fifo.sv
// rtl/fv_sync_fifo.sv - show-ahead synchronous FIFO; accepts a push while full if a pop happens in the same cycle
module fv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    assign rdata_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/fv_flag_reader.sv
// rtl/fv_flag_reader.sv - records every change of a flag bank into a FIFO with overflow tracking (FV_TIMESTAMP_EN adds timestamps)
module fv_flag_reader
    import fv_pkg::*;
#(
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic [FLAG_W-1:0]  FLAGS,
    input  logic               CLR,
    fv_flag_reader_if.master   rec,
    output logic               OVERFLOW,
    output logic [DROP_W-1:0]  DROP_CNT
);
    localparam int REC_W = rec_w(FLAG_W);

    logic [FLAG_W-1:0] prev_q;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] cnt_q, cnt_d;
    logic              change, drop, full, empty;
    logic [REC_W-1:0]  wdata, rdata;

    assign change = (FLAGS != prev_q);
    // Full only drops when the consumer is not freeing a slot this cycle.
    assign drop   = change && full && !rec.REC_READY;

`ifdef FV_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wdata         = {FLAGS, ts_q};
    assign rec.REC_FLAGS = rdata[REC_W-1:TS_W];
    assign rec.REC_TS    = rdata[TS_W-1:0];
`else
    assign wdata         = FLAGS;
    assign rec.REC_FLAGS = rdata;
`endif

    assign rec.REC_VALID = !empty;
    assign OVERFLOW      = ovf_q;
    assign DROP_CNT      = cnt_q;

    fv_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_X),
        .push_i  (change),
        .wdata_i (wdata),
        .pop_i   (rec.REC_READY),
        .full_o  (full),
        .empty_o (empty),
        .rdata_o (rdata)
    );

    // A drop coinciding with CLR must still be recorded.
    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (CLR) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (cnt_d != DROP_SAT) begin
                cnt_d = cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            prev_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= FLAGS;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fv_flag_reader.sv
// tb/tb_fv_flag_reader.sv - randomized bench for fv_flag_reader against a queue-based record model
module tb_fv_flag_reader;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST_X;
    logic [7:0] FLAGS;
    logic       CLR;
    logic       OVERFLOW;
    logic [3:0] DROP_CNT;

    fv_flag_reader_if #(.FLAG_W(8)) rec();

    fv_flag_reader #(.FLAG_W(8), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .FLAGS    (FLAGS),
        .CLR      (CLR),
        .rec      (rec),
        .OVERFLOW (OVERFLOW),
        .DROP_CNT (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq_f[$];
    int         mq_t[$];
    logic [7:0] m_prev;
    int         m_ts;
    bit         m_ovf;
    int         m_cnt;

    task automatic model_reset();
        mq_f.delete();
        mq_t.delete();
        m_prev = 8'h00;
        m_ts   = 0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
    endtask

    // Applies the current inputs to the model, then lets the DUT take the same edge.
    task automatic cyc();
        if (rec.REC_READY && mq_f.size() > 0) begin
            void'(mq_f.pop_front());
            void'(mq_t.pop_front());
        end
        if (CLR) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (FLAGS !== m_prev) begin
            if (mq_f.size() < DEPTH) begin
                mq_f.push_back(FLAGS);
                mq_t.push_back(m_ts);
            end else begin
                m_ovf = 1'b1;
                if (m_cnt < 15) m_cnt++;
            end
        end
        m_prev = FLAGS;
        m_ts   = (m_ts + 1) % 256;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        FLAGS = 8'h00;
        CLR = 1'b0;
        rec.REC_READY = 1'b0;
        RST_X = 1'b0;
        model_reset();
        #3;
        RST_X = 1'b1;
    endtask

    function automatic logic [7:0] new_flags(input logic [7:0] cur);
        logic [7:0] delta;
        delta = 8'($urandom_range(1, 255));
        return cur ^ delta;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (rec.REC_VALID !== 1'b0 || rec.REC_FLAGS !== 8'h00 || OVERFLOW !== 1'b0 || DROP_CNT !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b flags=%h ovf=%b cnt=%0d, required 0/00/0/0",
                     rec.REC_VALID, rec.REC_FLAGS, OVERFLOW, DROP_CNT);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (rec.REC_VALID !== 1'b0 || DROP_CNT !== 4'd0) begin
                errors++;
                $display("FAIL idle_zero cyc %0d: valid=%b cnt=%0d, required 0/0", i, rec.REC_VALID, DROP_CNT);
            end
        end
    endtask

    task automatic test_in_order();
        do_reset();
        rec.REC_READY = 1'b1;
        cyc();
        FLAGS = 8'h01;
        cyc();
        checks++;
        if (rec.REC_VALID !== 1'b1 || rec.REC_FLAGS !== 8'h01) begin
            errors++;
            $display("FAIL in_order_first: valid=%b flags=%h, required 1/01", rec.REC_VALID, rec.REC_FLAGS);
        end
`ifdef FV_TIMESTAMP_EN
        checks++;
        if (rec.REC_TS !== 8'd1) begin
            errors++;
            $display("FAIL in_order_ts1: ts=%0d, required 1", rec.REC_TS);
        end
`endif
        FLAGS = 8'h03;
        cyc();
        checks++;
        if (rec.REC_VALID !== 1'b1 || rec.REC_FLAGS !== 8'h03) begin
            errors++;
            $display("FAIL in_order_second: valid=%b flags=%h, required 1/03", rec.REC_VALID, rec.REC_FLAGS);
        end
`ifdef FV_TIMESTAMP_EN
        checks++;
        if (rec.REC_TS !== 8'd2) begin
            errors++;
            $display("FAIL in_order_ts2: ts=%0d, required 2", rec.REC_TS);
        end
`endif
        cyc();
        checks++;
        if (rec.REC_VALID !== 1'b0 || rec.REC_FLAGS !== 8'h00) begin
            errors++;
            $display("FAIL in_order_drained: valid=%b flags=%h, required 0/00", rec.REC_VALID, rec.REC_FLAGS);
        end
    endtask

    task automatic test_overflow();
        int popped;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            FLAGS = new_flags(FLAGS);
            cyc();
        end
        checks++;
        if (OVERFLOW !== 1'b1 || DROP_CNT !== 4'd2 || mq_f.size() != 4) begin
            errors++;
            $display("FAIL overflow_six: ovf=%b cnt=%0d, required 1/2", OVERFLOW, DROP_CNT);
        end
        CLR = 1'b1;
        cyc();
        CLR = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b0 || DROP_CNT !== 4'd0) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b cnt=%0d, required 0/0", OVERFLOW, DROP_CNT);
        end
        popped = 0;
        rec.REC_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rec.REC_VALID === 1'b1) begin
                checks++;
                if (mq_f.size() == 0 || rec.REC_FLAGS !== mq_f[0]) begin
                    errors++;
                    $display("FAIL overflow_drain %0d: flags=%h, required %h", i, rec.REC_FLAGS,
                             (mq_f.size() > 0) ? mq_f[0] : 8'h00);
                end
                popped++;
            end
            cyc();
        end
        checks++;
        if (popped != 4) begin
            errors++;
            $display("FAIL overflow_kept: records read=%0d, required 4", popped);
        end
        rec.REC_READY = 1'b0;
        for (int i = 0; i < 24; i++) begin
            FLAGS = new_flags(FLAGS);
            cyc();
        end
        checks++;
        if (DROP_CNT !== 4'd15 || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL drop_saturate: cnt=%0d ovf=%b, required 15/1", DROP_CNT, OVERFLOW);
        end
        CLR = 1'b1;
        FLAGS = new_flags(FLAGS);
        cyc();
        CLR = 1'b0;
        checks++;
        if (DROP_CNT !== 4'd1 || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_drop: cnt=%0d ovf=%b, required 1/1", DROP_CNT, OVERFLOW);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] oldest;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            FLAGS = new_flags(FLAGS);
            cyc();
        end
        oldest = mq_f[0];
        checks++;
        if (rec.REC_FLAGS !== oldest) begin
            errors++;
            $display("FAIL full_head: flags=%h, required %h", rec.REC_FLAGS, oldest);
        end
        rec.REC_READY = 1'b1;
        FLAGS = new_flags(FLAGS);
        cyc();
        rec.REC_READY = 1'b0;
        checks++;
        if (DROP_CNT !== 4'd0 || OVERFLOW !== 1'b0 || mq_f.size() != 4) begin
            errors++;
            $display("FAIL full_pop_nodrop: cnt=%0d ovf=%b, required 0/0", DROP_CNT, OVERFLOW);
        end
        checks++;
        if (rec.REC_FLAGS !== mq_f[0] || rec.REC_FLAGS === oldest) begin
            errors++;
            $display("FAIL full_pop_next: flags=%h, required %h", rec.REC_FLAGS, mq_f[0]);
        end
        FLAGS = new_flags(FLAGS);
        cyc();
        checks++;
        if (DROP_CNT !== 4'd1) begin
            errors++;
            $display("FAIL full_pop_occupancy: cnt=%0d, required 1", DROP_CNT);
        end
    endtask

    task automatic test_ts_wrap();
        do_reset();
        while (m_ts != 255) cyc();
        FLAGS = 8'h11;
        cyc();
        FLAGS = 8'h22;
        cyc();
        checks++;
        if (rec.REC_FLAGS !== 8'h11) begin
            errors++;
            $display("FAIL ts_wrap_first: flags=%h, required 11", rec.REC_FLAGS);
        end
`ifdef FV_TIMESTAMP_EN
        checks++;
        if (rec.REC_TS !== 8'hFF) begin
            errors++;
            $display("FAIL ts_wrap_ff: ts=%h, required ff", rec.REC_TS);
        end
`endif
        rec.REC_READY = 1'b1;
        cyc();
        rec.REC_READY = 1'b0;
        checks++;
        if (rec.REC_FLAGS !== 8'h22) begin
            errors++;
            $display("FAIL ts_wrap_second: flags=%h, required 22", rec.REC_FLAGS);
        end
`ifdef FV_TIMESTAMP_EN
        checks++;
        if (rec.REC_TS !== 8'h00) begin
            errors++;
            $display("FAIL ts_wrap_00: ts=%h, required 00", rec.REC_TS);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ef;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) FLAGS = new_flags(FLAGS);
            rec.REC_READY = ($urandom_range(0, 2) == 0);
            CLR = ($urandom_range(0, 19) == 0);
            cyc();
            ef = (mq_f.size() > 0) ? mq_f[0] : 8'h00;
            checks++;
            if (rec.REC_VALID !== (mq_f.size() > 0) || rec.REC_FLAGS !== ef) begin
                errors++;
                $display("FAIL random_head %0d: valid=%b flags=%h, required %b/%h",
                         i, rec.REC_VALID, rec.REC_FLAGS, (mq_f.size() > 0), ef);
            end
            checks++;
            if (OVERFLOW !== m_ovf || DROP_CNT !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL random_drop %0d: ovf=%b cnt=%0d, required %b/%0d", i, OVERFLOW, DROP_CNT, m_ovf, m_cnt);
            end
`ifdef FV_TIMESTAMP_EN
            checks++;
            if (rec.REC_TS !== ((mq_t.size() > 0) ? 8'(mq_t[0]) : 8'h00)) begin
                errors++;
                $display("FAIL random_ts %0d: ts=%0d, required %0d", i, rec.REC_TS, (mq_t.size() > 0) ? mq_t[0] : 0);
            end
`endif
        end
        CLR = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            FLAGS = new_flags(FLAGS);
            cyc();
        end
        #2;
        FLAGS = 8'h00;
        RST_X = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rec.REC_VALID !== 1'b0 || rec.REC_FLAGS !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: valid=%b flags=%h, required 0/00", rec.REC_VALID, rec.REC_FLAGS);
        end
        #1;
        RST_X = 1'b1;
        FLAGS = 8'h80;
        cyc();
        checks++;
        if (rec.REC_VALID !== 1'b1 || rec.REC_FLAGS !== 8'h80) begin
            errors++;
            $display("FAIL reset_first_rec: valid=%b flags=%h, required 1/80", rec.REC_VALID, rec.REC_FLAGS);
        end
        rec.REC_READY = 1'b1;
        cyc();
        checks++;
        if (rec.REC_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_single_rec: valid=%b, required 0", rec.REC_VALID);
        end
        rec.REC_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_full_pop();
        test_ts_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
